// File: rtl/fir_pkg.sv
// Shared FIR definitions: FSM state encoding and elaboration-time sizing helpers.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Counter width for a range of v values; never narrower than one bit.
  function automatic int cnt_width(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fir_filter_delay_line.sv
// Sample delay line: on each valid strobe din enters taps[0] and older samples move up.
module FirFilterDelayLine #(
  parameter int DataWidth = 16,
  parameter int TapsNum   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid,
  input  logic [DataWidth-1:0]               din,
  output logic [TapsNum-1:0][DataWidth-1:0]  taps
);

  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else if (valid) begin
      taps[0] <= din;
      for (int i = 1; i < TapsNum; i++) taps[i] <= taps[i-1];
    end
  end

endmodule

// File: rtl/fir_interp_serial.sv
// Polyphase interpolating FIR: one input per handshake, INTERP outputs per input,
// each phase computed by a single time-multiplexed multiply-accumulate.
module fir_interp_serial
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH       = 16,
  parameter int COEFF_WIDTH       = 8,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int OUTPUT_WIDTH_FULL = 27,
  parameter int INTERP            = 4,
  parameter int NUM_TAPS          = 16,
  parameter logic [NUM_TAPS*COEFF_WIDTH-1:0] COEFFS = {NUM_TAPS{COEFF_WIDTH'(1)}}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic signed [INPUT_WIDTH-1:0]  din,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic signed [OUTPUT_WIDTH-1:0] dout
);

  localparam int P    = ceil_div(NUM_TAPS, INTERP);
  localparam int NH   = P * INTERP;
  localparam int TW   = cnt_width(P);
  localparam int PHW  = cnt_width(INTERP);
  localparam int IW   = cnt_width(NH);
  localparam int PRW  = INPUT_WIDTH + COEFF_WIDTH;
  localparam int FULL = OUTPUT_WIDTH_FULL;

  fir_state_e state, state_nxt;

  logic [TW-1:0]                  tap;
  logic [PHW-1:0]                 phase;
  logic signed [FULL-1:0]         acc;
  logic [P-1:0][INPUT_WIDTH-1:0]  x;
  logic                           accept;
  logic                           last_tap;
  logic                           last_phase;

  assign ready_in   = (state == IDLE) && !rst;
  assign valid_out  = (state == OUT);
  assign accept     = valid_in && ready_in;
  assign last_tap   = (tap == TW'(P - 1));
  assign last_phase = (phase == PHW'(INTERP - 1));

  FirFilterDelayLine #(
    .DataWidth (INPUT_WIDTH),
    .TapsNum   (P)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .valid (accept),
    .din   (din),
    .taps  (x)
  );

  // Prototype padded to a whole number of phases; the padding taps read as zero.
  logic signed [COEFF_WIDTH-1:0] h_pad [NH];
  for (genvar i = 0; i < NH; i++) begin : g_h
    if (i < NUM_TAPS) begin : g_c
      assign h_pad[i] = COEFFS[i*COEFF_WIDTH +: COEFF_WIDTH];
    end else begin : g_z
      assign h_pad[i] = '0;
    end
  end

  logic [IW-1:0]                  idx;
  logic signed [COEFF_WIDTH-1:0]  coef;
  logic signed [PRW-1:0]          prod;
  logic signed [FULL-1:0]         prod_ext;
  logic signed [FULL-1:0]         sum;
  logic signed [OUTPUT_WIDTH-1:0] dout_nxt;

  assign idx      = IW'(tap) * IW'(INTERP) + IW'(phase);
  assign coef     = h_pad[idx];
  assign prod     = $signed(x[tap]) * coef;
  assign prod_ext = FULL'(prod);
  assign sum      = acc + prod_ext;

  if (OUTPUT_WIDTH <= FULL) begin : g_trunc
    assign dout_nxt = sum[FULL-1 -: OUTPUT_WIDTH];
  end else begin : g_sext
    assign dout_nxt = OUTPUT_WIDTH'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = MAC;
      MAC:     if (last_tap)  state_nxt = OUT;
      OUT:     if (ready_out) state_nxt = last_phase ? IDLE : MAC;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap   <= '0;
      phase <= '0;
      acc   <= '0;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          tap   <= '0;
          phase <= '0;
          acc   <= '0;
        end
        MAC: begin
          acc <= sum;
          if (last_tap) dout <= dout_nxt;
          else          tap  <= tap + 1'b1;
        end
        // dout stays put while the consumer stalls
        OUT: if (ready_out && !last_phase) begin
          phase <= phase + 1'b1;
          tap   <= '0;
          acc   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp_serial.sv
// Bench for fir_interp_serial: directed scenarios plus randomized traffic against a sum-of-products model.
module tb_fir_interp_serial;

  localparam int L = 2;
  localparam int N = 4;
  localparam int P = 2;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] din;
  logic        ready_out;
  logic        ready_in_a, ready_in_b;
  logic        valid_out_a, valid_out_b;
  logic [26:0] dout_a;
  logic [15:0] dout_b;
  logic        ready_in, valid_out;

  assign ready_in  = ready_in_a;
  assign valid_out = valid_out_a;

  fir_interp_serial #(
    .INPUT_WIDTH(16), .COEFF_WIDTH(8), .OUTPUT_WIDTH(27), .OUTPUT_WIDTH_FULL(27),
    .INTERP(L), .NUM_TAPS(N), .COEFFS(32'h04030201)
  ) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in_a), .din(din),
    .valid_out(valid_out_a), .ready_out(ready_out), .dout(dout_a)
  );

  fir_interp_serial #(
    .INPUT_WIDTH(16), .COEFF_WIDTH(8), .OUTPUT_WIDTH(16), .OUTPUT_WIDTH_FULL(27),
    .INTERP(L), .NUM_TAPS(N), .COEFFS(32'h00000080)
  ) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in_b), .din(din),
    .valid_out(valid_out_b), .ready_out(ready_out), .dout(dout_b)
  );

  always #5 clk = ~clk;

  int ha[4] = '{1, 2, 3, 4};
  int hb[4] = '{-128, 0, 0, 0};

  int          hist[$];
  logic [26:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [26:0] got_a[$];
  logic [15:0] got_b[$];
  int          acc_cyc[$];
  int          first_vo;
  int          cyc;
  int          n_checks;
  int          n_fail;

  // y_k = sum_j h[j*L+k] * x[j], wrapped to the 27-bit full width
  function automatic logic [26:0] ref_full(input int h[4], input int k);
    longint s;
    s = 0;
    for (int j = 0; j < P; j++)
      if (j < hist.size() && (j*L + k) < N) s += longint'(h[j*L + k]) * longint'(hist[j]);
    return s[26:0];
  endfunction

  task automatic step(input logic vin, input logic [15:0] d, input logic rout, input logic r);
    logic ri, vo;
    logic [26:0] t;
    valid_in = vin; din = d; ready_out = rout; rst = r;
    @(negedge clk);
    ri = ready_in; vo = valid_out;
    if (r) begin
      hist.delete(); exp_a.delete(); exp_b.delete();
    end else begin
      if (vin && ri) begin
        hist.push_front(int'($signed(d)));
        if (hist.size() > P) void'(hist.pop_back());
        for (int k = 0; k < L; k++) begin
          exp_a.push_back(ref_full(ha, k));
          t = ref_full(hb, k);
          exp_b.push_back(t[26:11]);
        end
        acc_cyc.push_back(cyc);
      end
      if (vo && rout) begin
        got_a.push_back(dout_a);
        got_b.push_back(dout_b);
        if (first_vo < 0) first_vo = cyc;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    step(0, 16'h0, 1, 1);
    step(0, 16'h0, 1, 1);
    got_a.delete(); got_b.delete(); acc_cyc.delete();
    first_vo = -1;
  endtask

  task automatic test_reset();
    step(0, 16'h0, 1, 1);
    step(0, 16'h0, 1, 1);
    n_checks++;
    if (ready_in !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in: got %b want 0", ready_in); end
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_checks++;
    if (dout_a !== 27'd0 || dout_b !== 16'd0) begin n_fail++; $display("FAIL reset_dout: got %0h/%0h want 0/0", dout_a, dout_b); end
    step(0, 16'h0, 1, 0);
    n_checks++;
    if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready_in: got %b want 1", ready_in); end
  endtask

  task automatic test_impulse();
    logic [26:0] want[6] = '{27'd100, 27'd200, 27'd300, 27'd400, 27'd0, 27'd0};
    do_reset();
    for (int i = 0; i < 200 && got_a.size() < 6; i++)
      step(acc_cyc.size() < 3, (acc_cyc.size() == 0) ? 16'd100 : 16'd0, 1, 0);
    n_checks++;
    if (got_a.size() < 6) begin
      n_fail++; $display("FAIL impulse_count: got %0d outputs want 6", got_a.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got_a[i] !== want[i]) begin n_fail++; $display("FAIL impulse_y%0d: got %0d want %0d", i, got_a[i], want[i]); end
      end
      n_checks++;
      if (first_vo - acc_cyc[0] != 3) begin n_fail++; $display("FAIL impulse_latency: got %0d want 3", first_vo - acc_cyc[0]); end
    end
  endtask

  task automatic test_step();
    do_reset();
    for (int i = 0; i < 60; i++) step(1, 16'd10, 1, 0);
    n_checks++;
    if (acc_cyc.size() < 6 || got_a.size() < 8) begin
      n_fail++; $display("FAIL step_count: got %0d accepts %0d outputs want >=6 >=8", acc_cyc.size(), got_a.size());
    end else begin
      for (int i = 1; i < acc_cyc.size(); i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 7) begin n_fail++; $display("FAIL step_period%0d: got %0d want 7", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
      for (int i = 2; i < got_a.size(); i++) begin
        n_checks++;
        if (got_a[i] !== ((i % 2 == 0) ? 27'd40 : 27'd60)) begin
          n_fail++; $display("FAIL step_y%0d: got %0d want %0d", i, got_a[i], (i % 2 == 0) ? 40 : 60);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [26:0] want[4] = '{27'd100, 27'd200, 27'd300, 27'd400};
    do_reset();
    step(1, 16'd100, 1, 0);
    for (int i = 0; i < 10 && valid_out !== 1'b1; i++) step(0, 16'd0, 1, 0);
    n_checks++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", valid_out); end
    for (int i = 0; i < 5; i++) begin
      step(1, 16'd0, 0, 0);
      n_checks++;
      if (valid_out !== 1'b1 || dout_a !== 27'd100 || ready_in !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got vo=%b dout=%0d ri=%b want vo=1 dout=100 ri=0", i, valid_out, dout_a, ready_in);
      end
    end
    for (int i = 0; i < 100 && got_a.size() < 4; i++) step(acc_cyc.size() < 2, 16'd0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 16'd0, 1, 0);
    n_checks++;
    if (got_a.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs want 4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_a[i] !== want[i]) begin n_fail++; $display("FAIL bp_y%0d: got %0d want %0d", i, got_a[i], want[i]); end
      end
    end
  endtask

  task automatic test_trunc();
    do_reset();
    step(1, 16'h8000, 1, 0);
    for (int i = 0; i < 50 && got_b.size() < 2; i++) step(0, 16'd0, 1, 0);
    n_checks++;
    if (got_b.size() < 2) begin
      n_fail++; $display("FAIL trunc_count: got %0d outputs want 2", got_b.size());
    end else begin
      n_checks++;
      if (got_b[0] !== 16'h0800) begin n_fail++; $display("FAIL trunc_y0: got %h want 0800", got_b[0]); end
      n_checks++;
      if (got_b[1] !== 16'h0000) begin n_fail++; $display("FAIL trunc_y1: got %h want 0000", got_b[1]); end
      n_checks++;
      if (got_a[0] !== 27'h7ff8000) begin n_fail++; $display("FAIL neg_y0: got %h want 7ff8000", got_a[0]); end
      n_checks++;
      if (got_a[1] !== 27'h7ff0000) begin n_fail++; $display("FAIL neg_y1: got %h want 7ff0000", got_a[1]); end
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [26:0] want[4] = '{27'd100, 27'd200, 27'd300, 27'd400};
    do_reset();
    step(1, 16'd100, 1, 0);
    step(0, 16'd0, 1, 0);
    step(1, 16'd77, 1, 1);
    step(0, 16'd0, 1, 0);
    n_checks++;
    if (ready_in !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_in: got %b want 1", ready_in); end
    for (int i = 0; i < 10; i++) step(0, 16'd0, 1, 0);
    n_checks++;
    if (got_a.size() != 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d outputs want 0", got_a.size()); end
    got_a.delete(); acc_cyc.delete();
    step(1, 16'd100, 1, 0);
    for (int i = 0; i < 100 && got_a.size() < 4; i++) step(acc_cyc.size() < 2, 16'd0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 16'd0, 1, 0);
    n_checks++;
    if (got_a.size() != 4) begin
      n_fail++; $display("FAIL midrst_count: got %0d outputs want 4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_a[i] !== want[i]) begin n_fail++; $display("FAIL midrst_y%0d: got %0d want %0d", i, got_a[i], want[i]); end
      end
    end
  endtask

  // Follows test_reset_mid_mac, whose last delivered value was 400.
  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      step(0, 16'($urandom), 1, 0);
      n_checks++;
      if (valid_out !== 1'b0 || ready_in !== 1'b1 || dout_a !== 27'd400) begin
        n_fail++; $display("FAIL idle%0d: got vo=%b ri=%b dout=%0d want vo=0 ri=1 dout=400", i, valid_out, ready_in, dout_a);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000 && (acc_cyc.size() < 40 || got_a.size() < exp_a.size()); i++)
      step((acc_cyc.size() < 40) && ($urandom_range(0, 1) == 1), 16'($urandom), $urandom_range(0, 3) != 0, 0);
    n_checks++;
    if (acc_cyc.size() != 40 || got_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d accepts %0d outputs want 40 %0d", acc_cyc.size(), got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < got_a.size(); i++) begin
        n_checks++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
          n_fail++; $display("FAIL rand_y%0d: got %h/%h want %h/%h", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    clk = 0; rst = 1; valid_in = 0; din = '0; ready_out = 1;
    cyc = 0; n_checks = 0; n_fail = 0; first_vo = -1;
    test_reset();
    test_impulse();
    test_step();
    test_backpressure();
    test_trunc();
    test_reset_mid_mac();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
